// File: rtl/chunk_addr_looper.sv
// Purpose : turns one chunk offset into a sequence of per-row DRAM burst commands.
// Latency : chunk accepted at cycle t -> first command valid at t+2; then 1 row/cycle.
// Backpressure: o_cmd_ack low holds every command output; the next chunk is
//               accepted only while the last row of the current chunk transfers.
//
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_mofs_rdy / i_mofs_ack      : chunk-offset handshake (i_mofs, i_id)
//   i_mbase, i_mstride,
//   i_row_stride, i_nrow,
//   i_row_len                    : per-configuration tables, static while a chunk is in flight
//   o_cmd_rdy / o_cmd_ack        : row-command handshake (o_addr, o_len, o_id, o_islast)

module chunk_addr_looper #(
    parameter  int WBW    = 16,
    parameter  int DIM    = 6,
    parameter  int N_ICFG = 4,
    parameter  int GBW    = 32,
    parameter  int CNT_BW = 8,
    localparam int ID_W   = $clog2(N_ICFG + 1)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    // chunk-offset handshake
    input  logic                                   i_mofs_rdy,
    output logic                                   i_mofs_ack,
    input  logic [DIM-1:0][WBW-1:0]                i_mofs,
    input  logic [ID_W-1:0]                        i_id,
    // configuration tables
    input  logic [N_ICFG-1:0][GBW-1:0]             i_mbase,
    input  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0]    i_mstride,
    input  logic [N_ICFG-1:0][GBW-1:0]             i_row_stride,
    input  logic [N_ICFG-1:0][CNT_BW-1:0]          i_nrow,
    input  logic [N_ICFG-1:0][CNT_BW-1:0]          i_row_len,
    // row-command handshake
    output logic                                   o_cmd_rdy,
    input  logic                                   o_cmd_ack,
    output logic [GBW-1:0]                         o_addr,
    output logic [CNT_BW-1:0]                      o_len,
    output logic [ID_W-1:0]                        o_id,
    output logic                                   o_islast
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [DIM-1:0][WBW-1:0]  mofs_q,  mofs_d;
    logic [ID_W-1:0]          id_q,    id_d;
    logic [GBW-1:0]           addr_q,  addr_d;
    logic [CNT_BW-1:0]        len_q,   len_d;
    logic [CNT_BW-1:0]        nrow_q,  nrow_d;
    logic [CNT_BW-1:0]        row_q,   row_d;

    // Configuration selected by the latched id. An id outside the table
    // selects all-zero values rather than aliasing onto another entry.
    logic [GBW-1:0]           mbase_sel;
    logic [DIM-1:0][GBW-1:0]  mstride_sel;
    logic [GBW-1:0]           row_stride_sel;
    logic [CNT_BW-1:0]        nrow_sel;
    logic [CNT_BW-1:0]        row_len_sel;

    always_comb begin
        mbase_sel      = '0;
        mstride_sel    = '0;
        row_stride_sel = '0;
        nrow_sel       = '0;
        row_len_sel    = '0;
        for (int k = 0; k < N_ICFG; k++) begin
            if (id_q == ID_W'(k)) begin
                mbase_sel      = i_mbase[k];
                mstride_sel    = i_mstride[k];
                row_stride_sel = i_row_stride[k];
                nrow_sel       = i_nrow[k];
                row_len_sel    = i_row_len[k];
            end
        end
    end

    // Chunk base address; all arithmetic wraps at 2^GBW.
    logic [GBW-1:0] base;

    always_comb begin
        base = mbase_sel;
        for (int d = 0; d < DIM; d++) begin
            base = base + GBW'(mofs_q[d]) * mstride_sel[d];
        end
    end

    // A row count of zero is treated as a single row.
    logic [CNT_BW-1:0] last_idx;
    logic              is_last;
    logic              cmd_xfer;

    assign last_idx  = (nrow_q == '0) ? '0 : nrow_q - CNT_BW'(1);
    assign is_last   = (row_q == last_idx);

    assign o_cmd_rdy = (state_q == S_EMIT);
    assign cmd_xfer  = o_cmd_rdy && o_cmd_ack;
    assign o_addr    = addr_q;
    assign o_len     = len_q;
    assign o_id      = id_q;
    assign o_islast  = o_cmd_rdy && is_last;

    // A new chunk is taken when idle, or in the very cycle the final row
    // transfers so back-to-back chunks only pay the CALC cycle.
    assign i_mofs_ack = !i_rst && i_mofs_rdy &&
                        ((state_q == S_IDLE) || (cmd_xfer && is_last));

    always_comb begin
        state_d = state_q;
        mofs_d  = mofs_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        nrow_d  = nrow_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (i_mofs_ack) begin
                    mofs_d  = i_mofs;
                    id_d    = i_id;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                addr_d  = base;
                row_d   = '0;
                nrow_d  = nrow_sel;
                len_d   = row_len_sel;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (cmd_xfer) begin
                    if (is_last) begin
                        if (i_mofs_ack) begin
                            mofs_d  = i_mofs;
                            id_d    = i_id;
                            state_d = S_CALC;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        row_d  = row_q + CNT_BW'(1);
                        addr_d = addr_q + row_stride_sel;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mofs_q  <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            nrow_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            mofs_q  <= mofs_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            nrow_q  <= nrow_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: tb/tb_chunk_addr_looper.sv
// Purpose : self-checking bench for chunk_addr_looper with directed and random chunks.
// Latency : reference model predicts each row command and the cycle it becomes valid.
// Backpressure: consumer ack is randomised or stalled on a chosen row.

module tb_chunk_addr_looper;

    localparam int WBW    = 16;
    localparam int DIM    = 6;
    localparam int N_ICFG = 4;
    localparam int GBW    = 32;
    localparam int CNT_BW = 8;
    localparam int ID_W   = $clog2(N_ICFG + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                 i_rst;
    logic                                 i_mofs_rdy;
    logic                                 i_mofs_ack;
    logic [DIM-1:0][WBW-1:0]              i_mofs;
    logic [ID_W-1:0]                      i_id;
    logic [N_ICFG-1:0][GBW-1:0]           mbase;
    logic [N_ICFG-1:0][DIM-1:0][GBW-1:0]  mstride;
    logic [N_ICFG-1:0][GBW-1:0]           row_stride;
    logic [N_ICFG-1:0][CNT_BW-1:0]        nrow;
    logic [N_ICFG-1:0][CNT_BW-1:0]        row_len;
    logic                                 o_cmd_rdy;
    logic                                 o_cmd_ack;
    logic [GBW-1:0]                       o_addr;
    logic [CNT_BW-1:0]                    o_len;
    logic [ID_W-1:0]                      o_id;
    logic                                 o_islast;

    chunk_addr_looper #(
        .WBW(WBW), .DIM(DIM), .N_ICFG(N_ICFG), .GBW(GBW), .CNT_BW(CNT_BW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_mofs_rdy   (i_mofs_rdy),
        .i_mofs_ack   (i_mofs_ack),
        .i_mofs       (i_mofs),
        .i_id         (i_id),
        .i_mbase      (mbase),
        .i_mstride    (mstride),
        .i_row_stride (row_stride),
        .i_nrow       (nrow),
        .i_row_len    (row_len),
        .o_cmd_rdy    (o_cmd_rdy),
        .o_cmd_ack    (o_cmd_ack),
        .o_addr       (o_addr),
        .o_len        (o_len),
        .o_id         (o_id),
        .o_islast     (o_islast)
    );

    typedef struct {
        logic [GBW-1:0]    addr;
        logic [CNT_BW-1:0] len;
        logic [ID_W-1:0]   id;
        logic              last;
        int                acc;
    } cmd_t;

    typedef struct {
        logic [ID_W-1:0]         id;
        logic [DIM-1:0][WBW-1:0] mofs;
    } chunk_t;

    int       n_assert = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    cmd_t     exp_q[$];
    chunk_t   pend_q[$];
    logic [GBW-1:0] log_addr[$];
    logic     log_last[$];
    int       ack_pct    = 100;
    int       rdy_pct    = 100;
    int       stall_row  = -1;
    int       stall_left = 0;
    bit       presenting = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    // Reference: row r of a chunk sits at base + r*row_stride, base being the
    // table base plus the dot product of offsets and strides, all mod 2^GBW.
    task automatic push_chunk(input chunk_t c, input int acc);
        int          k = int'(c.id);
        logic [63:0] b;
        int          nr;
        cmd_t        e;
        b = 64'(mbase[k]);
        for (int d = 0; d < DIM; d++) b += 64'(c.mofs[d]) * 64'(mstride[k][d]);
        nr = (nrow[k] == '0) ? 1 : int'(nrow[k]);
        for (int r = 0; r < nr; r++) begin
            e.addr = GBW'(b + 64'(r) * 64'(row_stride[k]));
            e.len  = row_len[k];
            e.id   = c.id;
            e.last = (r == nr - 1);
            e.acc  = acc;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: drive at edge+1, check at edge+2, advance to next edge+1.
    task automatic step();
        bit exp_rdy, xfer, exp_ack;
        if (!presenting && pend_q.size() > 0 && $urandom_range(99) < rdy_pct) begin
            presenting = 1'b1;
            i_mofs     = pend_q[0].mofs;
            i_id       = pend_q[0].id;
        end
        if (presenting) begin
            i_mofs_rdy = 1'b1;
        end else begin
            i_mofs_rdy = 1'b0;
            for (int d = 0; d < DIM; d++) i_mofs[d] = WBW'($urandom);
            i_id = ID_W'($urandom_range(N_ICFG));
        end
        o_cmd_ack = 1'b0;
        if (o_cmd_rdy) begin
            if (stall_row >= 0 && log_addr.size() == stall_row && stall_left > 0)
                stall_left--;
            else
                o_cmd_ack = ($urandom_range(99) < ack_pct);
        end
        #1;
        exp_rdy = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
        chk("cmd_rdy", o_cmd_rdy, exp_rdy);
        if (exp_rdy) begin
            chk("addr",   o_addr,   exp_q[0].addr);
            chk("len",    o_len,    exp_q[0].len);
            chk("id",     o_id,     exp_q[0].id);
            chk("islast", o_islast, exp_q[0].last);
        end
        xfer    = exp_rdy && o_cmd_ack;
        exp_ack = i_mofs_rdy && (exp_q.size() == 0 || (exp_q.size() == 1 && xfer));
        chk("mofs_ack", i_mofs_ack, exp_ack);
        if (xfer) begin
            log_addr.push_back(exp_q[0].addr);
            log_last.push_back(exp_q[0].last);
            void'(exp_q.pop_front());
        end
        if (exp_ack) begin
            push_chunk(pend_q.pop_front(), cyc);
            presenting = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_q.size() + pend_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"},    o_cmd_rdy, 0);
        chk({tag, "_addr"},   o_addr,    0);
        chk({tag, "_len"},    o_len,     0);
        chk({tag, "_id"},     o_id,      0);
        chk({tag, "_islast"}, o_islast,  0);
    endtask

    task automatic add_chunk(input int id, input int m0, input int m1);
        chunk_t c;
        c.id   = ID_W'(id);
        c.mofs = '0;
        c.mofs[0] = WBW'(m0);
        c.mofs[1] = WBW'(m1);
        pend_q.push_back(c);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_last.delete();
    endtask

    initial begin
        int start;
        int n;
        chunk_t c;

        mbase = '0; mstride = '0; row_stride = '0; nrow = '0; row_len = '0;
        i_mofs = '0; i_id = '0; o_cmd_ack = 1'b0;

        // Reset state, with a chunk offered to confirm reset blocks the ack.
        i_rst = 1'b1;
        i_mofs_rdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset_mofs_ack", i_mofs_ack, 0);
        i_rst = 1'b0;
        i_mofs_rdy = 1'b0;

        // Single chunk, fixed expected addresses.
        mbase[1] = 32'h1000;
        mstride[1][0] = 32'h100;
        mstride[1][1] = 32'h10;
        row_stride[1] = 32'h40;
        nrow[1] = 8'd3;
        row_len[1] = 8'd8;
        clear_log();
        add_chunk(1, 2, 3);
        drain(20);
        chk("single_count", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("single_a0", log_addr[0], 32'h1230);
            chk("single_a1", log_addr[1], 32'h1270);
            chk("single_a2", log_addr[2], 32'h12B0);
            chk("single_l0", log_last[0], 0);
            chk("single_l1", log_last[1], 0);
            chk("single_l2", log_last[2], 1);
        end

        // Zero row count gives exactly one last row.
        mbase[0] = 32'h2000;
        mstride[0][0] = 32'h4;
        nrow[0] = 8'd0;
        row_len[0] = 8'd5;
        clear_log();
        add_chunk(0, 7, 0);
        drain(20);
        chk("nrow0_count", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("nrow0_last", log_last[0], 1);
            chk("nrow0_addr", log_addr[0], 32'h201C);
        end

        // Back-to-back: second chunk taken on the last row, only CALC in between.
        clear_log();
        add_chunk(1, 2, 3);
        add_chunk(1, 0, 1);
        start = cyc;
        drain(40);
        chk("b2b_cycles", cyc - start, 9);
        chk("b2b_count", log_addr.size(), 6);
        if (log_addr.size() == 6) chk("b2b_a3", log_addr[3], 32'h1010);

        // Back-pressure for 5 cycles on row 1 with a next chunk waiting.
        clear_log();
        add_chunk(1, 2, 3);
        add_chunk(1, 2, 3);
        stall_row = 1;
        stall_left = 5;
        start = cyc;
        drain(60);
        chk("bp_cycles", cyc - start, 14);
        chk("bp_count", log_addr.size(), 6);
        stall_row = -1;
        stall_left = 0;

        // Address wrap.
        mbase[2] = 32'hFFFF_FFF0;
        for (int d = 0; d < DIM; d++) mstride[2][d] = '0;
        row_stride[2] = 32'h10;
        nrow[2] = 8'd2;
        row_len[2] = 8'd4;
        clear_log();
        add_chunk(2, 123, 456);
        drain(20);
        chk("wrap_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("wrap_a0", log_addr[0], 32'hFFFF_FFF0);
            chk("wrap_a1", log_addr[1], 32'h0000_0000);
        end

        // Reset during row 2 of 4, then a fresh chunk completes.
        mbase[3] = 32'h500;
        mstride[3][0] = 32'h8;
        row_stride[3] = 32'h8;
        nrow[3] = 8'd4;
        row_len[3] = 8'd2;
        clear_log();
        add_chunk(3, 1, 0);
        n = 0;
        while (log_addr.size() < 1 && n < 10) begin
            step();
            n++;
        end
        chk("rst_mid_reached", log_addr.size(), 1);
        chk("rst_mid_presenting", o_cmd_rdy, 1);
        i_rst = 1'b1;
        i_mofs_rdy = 1'b1;
        o_cmd_ack = 1'b0;
        presenting = 1'b0;
        #1;
        chk("rst_mid_ack", i_mofs_ack, 0);
        @(posedge clk);
        cyc++;
        #1;
        check_zero("rst_mid");
        i_rst = 1'b0;
        i_mofs_rdy = 1'b0;
        exp_q.delete();
        pend_q.delete();
        for (int i = 0; i < 4; i++) step();
        clear_log();
        add_chunk(3, 2, 0);
        drain(20);
        chk("rst_after_count", log_addr.size(), 4);
        if (log_addr.size() == 4) chk("rst_after_a3", log_addr[3], 32'h528);

        // Random configurations, chunks, offer and ack patterns.
        ack_pct = 70;
        rdy_pct = 70;
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < N_ICFG; k++) begin
                mbase[k] = $urandom;
                for (int d = 0; d < DIM; d++) mstride[k][d] = $urandom;
                row_stride[k] = $urandom;
                nrow[k] = CNT_BW'($urandom_range(0, 4));
                row_len[k] = CNT_BW'($urandom);
            end
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                c.id = ID_W'($urandom_range(0, N_ICFG - 1));
                for (int d = 0; d < DIM; d++) c.mofs[d] = WBW'($urandom);
                pend_q.push_back(c);
            end
            drain(400);
            for (int j = 0; j < $urandom_range(0, 2); j++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
